// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Covers the fetch state encoding, the bus widths and the buffered {pc, instr} entry.
package instr_fetch_ctrl_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, instruction memory, the sequencer and decode.
// The master modport is the fetch controller; the slave modport is its environment.
interface instr_fetch_ctrl_if;
  import instr_fetch_ctrl_pkg::*;

  logic [ADDR_W-1:0]  A_InstrAddress;
  logic               C_IMRead;
  logic [INSTR_W-1:0] D_Instruction;
  logic               C_Start;
  logic               C_Halt;
  logic               C_Redirect;
  logic [ADDR_W-1:0]  A_RedirectTarget;
  logic [INSTR_W-1:0] D_FetchInstr;
  logic [ADDR_W-1:0]  A_FetchPC;
  logic               C_FetchValid;
  logic               C_DecodeReady;
  logic               C_Busy;

  modport master (
    output A_InstrAddress, C_IMRead, D_FetchInstr, A_FetchPC, C_FetchValid, C_Busy,
    input  D_Instruction, C_Start, C_Halt, C_Redirect, A_RedirectTarget, C_DecodeReady
  );

  modport slave (
    input  A_InstrAddress, C_IMRead, D_FetchInstr, A_FetchPC, C_FetchValid, C_Busy,
    output D_Instruction, C_Start, C_Halt, C_Redirect, A_RedirectTarget, C_DecodeReady
  );

endinterface

// File: rtl/instr_fetch_ctrl_fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
// The head output keeps showing the last presented entry while the FIFO is empty.
module fetch_buffer
  import instr_fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [OW-1:0] occ,
  output fetch_entry_t head
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [OW-1:0] count_reg;
  fetch_entry_t  last_reg;
  fetch_entry_t  mem [DEPTH];
  logic          not_empty;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (count_reg != '0);
  assign do_push   = push && !flush;
  assign do_pop    = pop && not_empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= '0;
    end else begin
      if (not_empty) begin
        last_reg <= mem[rd_ptr_reg];
      end
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + OW'(do_push) - OW'(do_pop);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == AW'(gi))) begin
        mem[gi] <= wr_entry;
      end
    end
  end

  assign occ  = count_reg;
  assign head = not_empty ? mem[rd_ptr_reg] : last_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one-cycle-latency memory reads
// under a credit rule, buffers returns and hands them to decode with valid/ready.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int                DEPTH        = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_ctrl_if.master  bus
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = OW + 1;

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] tag_reg;
  logic              inflight_reg;
  logic              issue;
  logic              pop;
  logic              valid;
  logic              credit_ok;
  logic [OW-1:0]     occ;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;

  assign valid = (occ != '0);
  assign pop   = valid && bus.C_DecodeReady;

  // A slot freed by this cycle's pop can be reused by the read issued now.
  assign credit_ok = (CW'(occ) + CW'(inflight_reg)) < (CW'(DEPTH) + CW'(pop));

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    if (bus.C_Redirect) begin
      state_next = ST_FETCH;
    end else if (bus.C_Halt) begin
      if ((state_reg == ST_FETCH) && !inflight_reg) state_next = ST_HALTED;
    end else if (bus.C_Start && (state_reg != ST_FETCH)) begin
      state_next = ST_FETCH;
    end
    issue = (state_reg == ST_FETCH) && !bus.C_Halt && !bus.C_Redirect && credit_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_VECTOR;
      tag_reg      <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (bus.C_Redirect) begin
        pc_reg <= bus.A_RedirectTarget;
      end else if (issue) begin
        pc_reg  <= pc_reg + 1'b1;
        tag_reg <= pc_reg;
      end
    end
  end

  assign wr_entry = '{pc: tag_reg, instr: bus.D_Instruction};

  // Redirect flushes the buffer and drops the word returning this cycle.
  fetch_buffer #(.DEPTH(DEPTH)) u_fetch_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_reg && !bus.C_Redirect),
    .pop      (pop),
    .flush    (bus.C_Redirect),
    .wr_entry (wr_entry),
    .occ      (occ),
    .head     (head)
  );

  assign bus.A_InstrAddress = pc_reg;
  assign bus.C_IMRead       = issue;
  assign bus.D_FetchInstr   = head.instr;
  assign bus.A_FetchPC      = head.pc;
  assign bus.C_FetchValid   = valid;
  assign bus.C_Busy         = (state_reg == ST_FETCH) || inflight_reg || valid;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: one DUT at the default reset vector, one at FFFF,
// each fed by a registered-read memory model.
module tb_instr_fetch_ctrl;
  import instr_fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if ifc0 ();
  instr_fetch_ctrl_if ifc1 ();

  instr_fetch_ctrl #(.RESET_VECTOR(16'h0000), .DEPTH(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0)
  );

  instr_fetch_ctrl #(.RESET_VECTOR(16'hFFFF), .DEPTH(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1)
  );

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0000: mem_val = 16'h1111;
      16'h0001: mem_val = 16'h2222;
      16'h0002: mem_val = 16'h3333;
      default:  mem_val = a ^ 16'hA5A5;
    endcase
  endfunction

  logic [15:0] rd0 = '0;
  logic [15:0] rd1 = '0;
  always @(posedge clk) begin
    if (ifc0.C_IMRead) rd0 <= mem_val(ifc0.A_InstrAddress);
    if (ifc1.C_IMRead) rd1 <= mem_val(ifc1.A_InstrAddress);
  end
  assign ifc0.D_Instruction = rd0;
  assign ifc1.D_Instruction = rd1;

  logic [31:0] acc_q[$];
  always @(posedge clk) begin
    if (!rst && ifc0.C_FetchValid && ifc0.C_DecodeReady) begin
      acc_q.push_back({ifc0.A_FetchPC, ifc0.D_FetchInstr});
      $display("xfer pc=%h instr=%h", ifc0.A_FetchPC, ifc0.D_FetchInstr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_acc [9];

  initial begin
    exp_acc = '{32'h0000_1111, 32'h0001_2222, 32'h0002_3333, 32'h0003_A5A6, 32'h0004_A5A1,
                32'h0040_A5E5, 32'h0041_A5E4, 32'h000E_A5AB, 32'h000F_A5AA};
    ifc0.C_Start = 0; ifc0.C_Halt = 0; ifc0.C_Redirect = 0;
    ifc0.A_RedirectTarget = '0; ifc0.C_DecodeReady = 0;
    ifc1.C_Start = 0; ifc1.C_Halt = 0; ifc1.C_Redirect = 0;
    ifc1.A_RedirectTarget = '0; ifc1.C_DecodeReady = 0;

    // Reset held, then idle without start
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ifc0.C_FetchValid, 0);
    chk("rst_imread", ifc0.C_IMRead, 0);
    chk("rst_busy", ifc0.C_Busy, 0);
    chk("rst_instr", ifc0.D_FetchInstr, 0);
    chk("rst_fpc", ifc0.A_FetchPC, 0);
    chk("rst_addr", ifc0.A_InstrAddress, 16'h0000);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      chk("idle_imread", ifc0.C_IMRead, 0);
      chk("idle_busy", ifc0.C_Busy, 0);
    end

    // Start and latency
    ifc0.C_Start = 1; ifc0.C_DecodeReady = 1;
    step(); ifc0.C_Start = 0; #1;
    chk("t0_imread", ifc0.C_IMRead, 1);
    chk("t0_addr", ifc0.A_InstrAddress, 16'h0000);
    chk("t0_valid", ifc0.C_FetchValid, 0);
    step(); #1;
    chk("t1_valid", ifc0.C_FetchValid, 0);
    chk("t1_addr", ifc0.A_InstrAddress, 16'h0001);
    step(); #1;
    chk("t2_valid", ifc0.C_FetchValid, 1);
    chk("t2_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0000_1111);
    step(); #1;
    chk("t3_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0001_2222);

    // Back-pressure for 6 cycles
    step(); ifc0.C_DecodeReady = 0; #1;
    chk("t4_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0002_3333);
    chk("t4_imread", ifc0.C_IMRead, 0);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("bp_imread", ifc0.C_IMRead, 0);
      chk("bp_valid", ifc0.C_FetchValid, 1);
      chk("bp_hold", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0002_3333);
    end
    step(); ifc0.C_DecodeReady = 1; #1;
    chk("rel_imread", ifc0.C_IMRead, 1);
    chk("rel_addr", ifc0.A_InstrAddress, 16'h0004);
    step(); step();

    // Redirect with 0005 buffered and 0006 in flight
    step(); ifc0.C_DecodeReady = 0; ifc0.C_Redirect = 1; ifc0.A_RedirectTarget = 16'h0040; #1;
    chk("rd_head_pc", ifc0.A_FetchPC, 16'h0005);
    chk("rd_imread", ifc0.C_IMRead, 0);
    step(); ifc0.C_Redirect = 0; ifc0.C_DecodeReady = 1; #1;
    chk("rd_valid0", ifc0.C_FetchValid, 0);
    chk("rd_imread1", ifc0.C_IMRead, 1);
    chk("rd_addr", ifc0.A_InstrAddress, 16'h0040);
    step(); #1;
    chk("rd_valid1", ifc0.C_FetchValid, 0);
    step(); #1;
    chk("rd_valid2", ifc0.C_FetchValid, 1);
    chk("rd_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0040_A5E5);

    // Redirect to 000E, then halt at PC 0010
    step(); ifc0.C_Redirect = 1; ifc0.A_RedirectTarget = 16'h000E; #1;
    chk("r2_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0041_A5E4);
    step(); ifc0.C_Redirect = 0; #1;
    chk("r2_addr", ifc0.A_InstrAddress, 16'h000E);
    chk("r2_imread", ifc0.C_IMRead, 1);
    step();
    step(); ifc0.C_Halt = 1; #1;
    chk("h_addr", ifc0.A_InstrAddress, 16'h0010);
    chk("h_imread", ifc0.C_IMRead, 0);
    chk("h_head_pc", ifc0.A_FetchPC, 16'h000E);
    step(); #1;
    chk("h1_head_pc", ifc0.A_FetchPC, 16'h000F);
    chk("h1_busy", ifc0.C_Busy, 1);
    chk("h1_imread", ifc0.C_IMRead, 0);
    step(); #1;
    chk("h2_valid", ifc0.C_FetchValid, 0);
    chk("h2_busy", ifc0.C_Busy, 0);
    chk("h2_hold_pc", ifc0.A_FetchPC, 16'h000F);
    ifc0.C_Halt = 0;
    step(); #1;
    chk("h3_imread", ifc0.C_IMRead, 0);
    chk("h3_busy", ifc0.C_Busy, 0);
    ifc0.C_Start = 1;
    step(); ifc0.C_Start = 0; #1;
    chk("res_imread", ifc0.C_IMRead, 1);
    chk("res_addr", ifc0.A_InstrAddress, 16'h0010);
    step();
    step(); ifc0.C_DecodeReady = 0; #1;
    chk("res_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0010_A5B5);

    chk("acc_count", acc_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("acc%0d", i), (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_DEAD, exp_acc[i]);
    end

    // Asynchronous reset with a full buffer
    step(); #1;
    chk("full_head_pc", ifc0.A_FetchPC, 16'h0010);
    #2; rst = 1; #1;
    chk("ar_valid", ifc0.C_FetchValid, 0);
    chk("ar_busy", ifc0.C_Busy, 0);
    chk("ar_head", {ifc0.A_FetchPC, ifc0.D_FetchInstr}, 32'h0000_0000);
    chk("ar_addr", ifc0.A_InstrAddress, 16'h0000);
    @(posedge clk); #1; rst = 0;
    step(); #1;
    chk("post_valid", ifc0.C_FetchValid, 0);
    chk("post_busy", ifc0.C_Busy, 0);

    // Reset vector FFFF wraps to 0000
    ifc1.C_DecodeReady = 1;
    chk("v_addr", ifc1.A_InstrAddress, 16'hFFFF);
    ifc1.C_Start = 1;
    step(); ifc1.C_Start = 0; #1;
    chk("v0_imread", ifc1.C_IMRead, 1);
    chk("v0_addr", ifc1.A_InstrAddress, 16'hFFFF);
    step(); #1;
    chk("v1_addr", ifc1.A_InstrAddress, 16'h0000);
    chk("v1_valid", ifc1.C_FetchValid, 0);
    step(); #1;
    chk("v2_head", {ifc1.A_FetchPC, ifc1.D_FetchInstr}, 32'hFFFF_5A5A);
    step(); #1;
    chk("v3_head", {ifc1.A_FetchPC, ifc1.D_FetchInstr}, 32'h0000_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
